// File: rtl/tile_fetch_ctrl_if.sv
// Tile-map RAM port and CPU write-request bus shared by the fetch controller
// (master) and the RAM/CPU side (slave).
interface tile_fetch_ctrl_if;
    logic [12:0] map_addr;
    logic        map_we;
    logic [3:0]  map_wdata;
    logic [3:0]  map_rdata;
    logic        cpu_req;
    logic [12:0] cpu_addr;
    logic [3:0]  cpu_data;
    logic        cpu_ack;

    modport master (
        output map_addr, map_we, map_wdata, cpu_ack,
        input  map_rdata, cpu_req, cpu_addr, cpu_data
    );

    modport slave (
        input  map_addr, map_we, map_wdata, cpu_ack,
        output map_rdata, cpu_req, cpu_addr, cpu_data
    );
endinterface

// File: rtl/tile_fetch_ctrl.sv
// Raster timing plus tile-map fetch; display fetches own the single RAM port
// and CPU writes slip into any other cycle.
module tile_fetch_ctrl #(
    parameter int HTOTAL  = 800,
    parameter int VTOTAL  = 521,
    parameter int HLEFT   = 144,
    parameter int VTOP    = 31,
    parameter int HSYNC_W = 96,
    parameter int VSYNC_W = 2,
    parameter int TCOLS   = 80
) (
    input  logic               clk1,
    input  logic               rst_n,
    tile_fetch_ctrl_if.master  bus,
    output logic [9:0]         hcount,
    output logic [9:0]         vcount,
    output logic               hsync,
    output logic               vsync,
    output logic               bright,
    output logic [3:0]         tselect
);
    // Fetch leads the tile by three clocks: address, RAM latency, next-tile reg.
    localparam int FETCH_H0 = HLEFT - 3;
    localparam int FETCH_H1 = FETCH_H0 + 8 * (TCOLS - 1);
    localparam int HLAST    = HLEFT + 8 * TCOLS - 1;
    localparam int VLAST    = VTOP + 479;

    logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d;
    logic        run_q, run_d;
    logic [12:0] addr_q, addr_d;
    logic [3:0]  wdata_q, wdata_d;
    logic [3:0]  next_q, next_d;
    logic [3:0]  tsel_q, tsel_d;
    logic [2:1]  vld_pipe_q, vld_pipe_d;

    logic [9:0]  hoff, vrow, hcol;
    logic        vis_v, fetch, wr;
    logic [12:0] fetch_addr;

    always_comb begin
        hoff  = hcount_q - 10'(FETCH_H0);
        hcol  = hoff >> 3;
        vrow  = (vcount_q - 10'(VTOP)) >> 3;
        vis_v = (vcount_q >= 10'(VTOP)) && (vcount_q <= 10'(VLAST));
        fetch = vis_v && (hcount_q >= 10'(FETCH_H0)) && (hcount_q <= 10'(FETCH_H1))
                && (hoff[2:0] == 3'd0);
        fetch_addr = 13'(vrow) * 13'(TCOLS) + 13'(hcol);
        // run_q keeps the bus quiet until the first edge after reset release.
        wr = run_q && bus.cpu_req && !fetch;

        hcount_d = hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == 10'(HTOTAL - 1)) begin
            hcount_d = 10'd0;
            vcount_d = (vcount_q == 10'(VTOTAL - 1)) ? 10'd0 : vcount_q + 10'd1;
        end

        addr_d     = fetch ? fetch_addr : (wr ? bus.cpu_addr : addr_q);
        wdata_d    = wr ? bus.cpu_data : wdata_q;
        run_d      = 1'b1;
        vld_pipe_d = {vld_pipe_q[1], fetch};
        next_d     = vld_pipe_q[1] ? bus.map_rdata : next_q;
        tsel_d     = vld_pipe_q[2] ? next_q : tsel_q;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q   <= '0;
            vcount_q   <= '0;
            run_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            vld_pipe_q <= '0;
            next_q     <= '0;
            tsel_q     <= '0;
        end else begin
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            run_q      <= run_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            vld_pipe_q <= vld_pipe_d;
            next_q     <= next_d;
            tsel_q     <= tsel_d;
        end
    end

    assign bus.map_addr  = addr_d;
    assign bus.map_wdata = wdata_d;
    assign bus.map_we    = wr;
    assign bus.cpu_ack   = wr;

    assign hcount  = hcount_q;
    assign vcount  = vcount_q;
    assign hsync   = (hcount_q >= 10'(HSYNC_W));
    assign vsync   = (vcount_q >= 10'(VSYNC_W));
    assign bright  = (hcount_q >= 10'(HLEFT)) && (hcount_q <= 10'(HLAST)) && vis_v;
    assign tselect = tsel_q;
endmodule

// File: tb/tb_tile_fetch_ctrl.sv
// Directed bench for tile_fetch_ctrl: raster timing, tile fetch/display,
// CPU write arbitration and asynchronous reset.
module tb_tile_fetch_ctrl;
    logic clk1 = 1'b0;
    logic rst_n;
    always #5 clk1 = ~clk1;

    tile_fetch_ctrl_if bus();
    logic [9:0] hcount, vcount;
    logic       hsync, vsync, bright;
    logic [3:0] tselect;

    tile_fetch_ctrl dut (
        .clk1(clk1), .rst_n(rst_n), .bus(bus),
        .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .bright(bright), .tselect(tselect)
    );

    // Single-port tile RAM, one-cycle read latency, preloaded with k mod 16.
    logic [3:0] mem [0:8191];
    logic       preloaded = 1'b0;
    always @(posedge clk1) begin
        if (!preloaded) begin
            for (int k = 0; k < 8192; k++) mem[k] <= 4'(k % 16);
            preloaded <= 1'b1;
        end else if (bus.map_we) begin
            mem[bus.map_addr] <= bus.map_wdata;
        end
        bus.map_rdata <= mem[bus.map_addr];
    end

    typedef struct packed { logic [12:0] addr; logic [3:0] data; } wr_t;
    wr_t        sb[$];
    logic [3:0] exp_tile [0:8191];
    int npass = 0, ntot = 0;
    int hs_lo, vs_lo, br_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntot++;
        assert (obs === expv) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic adv();
        @(posedge clk1); #1;
    endtask

    task automatic smp();
        @(negedge clk1);
        if (!hsync) hs_lo++;
        if (!vsync) vs_lo++;
        if (bright) br_cnt++;
    endtask

    task automatic zero_cnt();
        hs_lo = 0; vs_lo = 0; br_cnt = 0;
    endtask

    task automatic wait_at(input int h, input int v, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 30000 && !hit; i++) begin
            adv(); smp();
            hit = (hcount == 10'(h)) && (vcount == 10'(v));
        end
        check({tag, "_reached"}, 32'(hit), 32'd1);
    endtask

    task automatic sb_check(input string tag);
        wr_t e;
        check({tag, "_pending"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_we"},    32'(bus.map_we),    32'd1);
            check({tag, "_addr"},  32'(bus.map_addr),  32'(e.addr));
            check({tag, "_wdata"}, 32'(bus.map_wdata), 32'(e.data));
        end
    endtask

    task automatic cpu_write(input logic [12:0] a, input logic [3:0] d, input string tag);
        int lat = 0;
        bit got = 1'b0;
        adv();
        bus.cpu_req = 1'b1; bus.cpu_addr = a; bus.cpu_data = d;
        sb.push_back(wr_t'{addr: a, data: d});
        while (lat < 3 && !got) begin
            smp();
            if (bus.cpu_ack) got = 1'b1;
            else begin lat++; adv(); end
        end
        check({tag, "_acked"}, 32'(got), 32'd1);
        if (got) sb_check(tag);
        check({tag, "_lat_le1"}, 32'(lat <= 1), 32'd1);
        adv(); bus.cpu_req = 1'b0; smp();
        check({tag, "_ack_drop"}, 32'(bus.cpu_ack), 32'd0);
        exp_tile[a] = d;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hcount"}, 32'(hcount), 0);
        check({tag, "_vcount"}, 32'(vcount), 0);
        check({tag, "_hsync"},  32'(hsync), 0);
        check({tag, "_vsync"},  32'(vsync), 0);
        check({tag, "_bright"}, 32'(bright), 0);
        check({tag, "_tsel"},   32'(tselect), 0);
        check({tag, "_we"},     32'(bus.map_we), 0);
        check({tag, "_addr"},   32'(bus.map_addr), 0);
        check({tag, "_wdata"},  32'(bus.map_wdata), 0);
        check({tag, "_ack"},    32'(bus.cpu_ack), 0);
    endtask

    task automatic check_release(input string tag);
        #1 rst_n = 1'b1; bus.cpu_req = 1'b0;
        #1 check({tag, "_h0"}, 32'(hcount), 0);
        adv(); smp(); check({tag, "_h1"}, 32'(hcount), 1);
        adv(); smp(); check({tag, "_h2"}, 32'(hcount), 2);
    endtask

    initial begin
        for (int k = 0; k < 8192; k++) exp_tile[k] = 4'(k % 16);
        zero_cnt();
        rst_n = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_addr = 13'd123; bus.cpu_data = 4'd7;
        repeat (3) smp();
        check_reset_state("rst0");
        check_release("rel0");

        // Back-to-back writes in vertical blank: one ack per clock.
        for (int i = 0; i < 20; i++) begin
            adv();
            bus.cpu_req = 1'b1; bus.cpu_addr = 13'(200 + i); bus.cpu_data = 4'(i);
            sb.push_back(wr_t'{addr: 13'(200 + i), data: 4'(i)});
            smp();
            check("burst_ack", 32'(bus.cpu_ack), 1);
            sb_check("burst");
            exp_tile[200 + i] = 4'(i);
        end
        adv(); bus.cpu_req = 1'b0; smp();
        check("idle_ack", 32'(bus.cpu_ack), 0);
        check("idle_we", 32'(bus.map_we), 0);
        check("idle_addr_hold", 32'(bus.map_addr), 219);

        wait_at(799, 0, "l0end"); zero_cnt();
        wait_at(799, 2, "l2end");
        check("vsync_lo_l1_2", vs_lo, 800);
        check("hsync_lo_l1_2", hs_lo, 192);
        check("bright_l1_2", br_cnt, 0);

        wait_at(799, 29, "l29end"); zero_cnt();
        wait_at(799, 30, "l30end");
        check("hsync_lo_l30", hs_lo, 96);
        check("bright_l30", br_cnt, 0);
        check("vsync_lo_l30", vs_lo, 0);
        zero_cnt();

        // Request landing on the first fetch of the frame is deferred one clock.
        wait_at(140, 31, "l31_140");
        adv(); bus.cpu_req = 1'b1; bus.cpu_addr = 13'd5; bus.cpu_data = 4'hA;
        sb.push_back(wr_t'{addr: 13'd5, data: 4'hA});
        smp();
        check("coll_h141", 32'(hcount), 141);
        check("coll_ack0", 32'(bus.cpu_ack), 0);
        check("coll_we0", 32'(bus.map_we), 0);
        check("coll_fetch_addr", 32'(bus.map_addr), 0);
        adv(); smp();
        check("coll_ack1", 32'(bus.cpu_ack), 1);
        sb_check("coll");
        exp_tile[5] = 4'hA;
        adv(); bus.cpu_req = 1'b0; smp();
        check("coll_ack_drop", 32'(bus.cpu_ack), 0);
        for (int h = 144; h <= 783; h++) begin
            adv(); smp();
            check("tsel_l31", 32'(tselect), 32'(exp_tile[(h - 144) >> 3]));
        end
        wait_at(799, 31, "l31end");
        check("bright_l31", br_cnt, 640);
        check("hsync_lo_l31", hs_lo, 96);

        wait_at(9, 32, "l32_9");
        cpu_write(13'd81, 4'hC, "wr81");
        cpu_write(13'd5000, 4'h3, "wr5000");
        wait_at(140, 33, "l33_140");
        cpu_write(13'd300, 4'h6, "wr_coll");

        wait_at(143, 39, "l39_143");
        for (int h = 144; h <= 783; h++) begin
            adv(); smp();
            check("tsel_l39", 32'(tselect), 32'(exp_tile[80 + ((h - 144) >> 3)]));
            if (h >= 149 && h <= 773 && ((h - 141) % 8) == 0) begin
                check("faddr_l39", 32'(bus.map_addr), 32'(80 + (h - 141) / 8));
                check("fwe_l39", 32'(bus.map_we), 0);
            end
        end
        wait_at(790, 39, "l39_790");
        check("tsel_hold", 32'(tselect), 32'(exp_tile[159]));

        // Reset dropped in the middle of a write cycle.
        wait_at(399, 40, "l40_399");
        adv(); bus.cpu_req = 1'b1; bus.cpu_addr = 13'd77; bus.cpu_data = 4'h9;
        smp();
        check("midwr_ack", 32'(bus.cpu_ack), 1);
        check("midwr_we", 32'(bus.map_we), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_state("rst1");
        smp(); check("rst1_we_held", 32'(bus.map_we), 0);
        smp(); check("rst1_h_held", 32'(hcount), 0);
        check_release("rel1");

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
